// File: rtl/zap_fetch_queue.sv
// zap_fetch_queue
// Buffers fetched instruction words between the fetch unit and decode.
// Words pass through a DEPTH-entry FIFO into a registered output stage.
// When the FIFO is empty, an incoming word bypasses it and reaches the
// output stage one cycle later. A fetch abort is written with
// ABORT_PAYLOAD as its instruction word. After an abort the queue sleeps
// and drops every later word until a flush.
//
// Ports:
//   i_clk, i_reset               clock; synchronous active-high reset
//   i_clear_from_writeback       flush (highest priority)
//   i_data_stall                 hold outputs
//   i_clear_from_alu             flush
//   i_stall_from_shifter/issue/decode  hold outputs
//   i_clear_from_decode          flush (lowest priority)
//   i_pc_ff, i_cpsr_t            PC of incoming word, Thumb state
//   i_instruction, i_valid       fetched word and its valid flag
//   i_instr_abort                fetch abort (may come without i_valid)
//   o_ready                      queue accepts a word this cycle
//   o_level                      entries held in the FIFO (not the output reg)
//   o_instruction, o_valid, o_instr_abort, o_pc_ff, o_pc_plus_8_ff
//                                registered output to decode
module zap_fetch_queue #(
  parameter int          DEPTH         = 4,
  parameter logic [31:0] ABORT_PAYLOAD = 32'd0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clear_from_writeback,
  input  logic                       i_data_stall,
  input  logic                       i_clear_from_alu,
  input  logic                       i_stall_from_shifter,
  input  logic                       i_stall_from_issue,
  input  logic                       i_stall_from_decode,
  input  logic                       i_clear_from_decode,
  input  logic [31:0]                i_pc_ff,
  input  logic                       i_cpsr_t,
  input  logic [31:0]                i_instruction,
  input  logic                       i_valid,
  input  logic                       i_instr_abort,
  output logic                       o_ready,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [31:0]                o_instruction,
  output logic                       o_valid,
  output logic                       o_instr_abort,
  output logic [31:0]                o_pc_ff,
  output logic [31:0]                o_pc_plus_8_ff
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic        abort;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc8;
  } entry_t;

  typedef enum logic [1:0] {ACT_ADVANCE, ACT_HOLD, ACT_FLUSH} action_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [LW-1:0]   level;
  logic            sleep;

  action_t         action;
  entry_t          in_entry;
  logic            write, push, pop, empty;

  assign o_level = level;
  assign o_ready = (level != LW'(DEPTH)) & ~sleep;
  assign empty   = (level == '0);

  always_comb begin
    action = ACT_ADVANCE;
    if (i_clear_from_writeback)
      action = ACT_FLUSH;
    else if (i_data_stall)
      action = ACT_HOLD;
    else if (i_clear_from_alu)
      action = ACT_FLUSH;
    else if (i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode)
      action = ACT_HOLD;
    else if (i_clear_from_decode)
      action = ACT_FLUSH;

    in_entry.instr = i_instr_abort ? ABORT_PAYLOAD : i_instruction;
    in_entry.abort = i_instr_abort;
    in_entry.valid = i_valid;
    in_entry.pc    = i_pc_ff;
    in_entry.pc8   = i_pc_ff + (i_cpsr_t ? 32'd4 : 32'd8);

    // o_ready already folds in sleep.
    write = (i_valid | i_instr_abort) & o_ready & (action != ACT_FLUSH);
    pop   = (action == ACT_ADVANCE) & ~empty;
    // An advance on an empty queue consumes the write via the bypass path.
    push  = write & ~((action == ACT_ADVANCE) & empty);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      level          <= '0;
      sleep          <= 1'b0;
      o_valid        <= 1'b0;
      o_instr_abort  <= 1'b0;
      o_instruction  <= '0;
      o_pc_ff        <= '0;
      o_pc_plus_8_ff <= 32'd8;
    end else if (action == ACT_FLUSH) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      level          <= '0;
      sleep          <= 1'b0;
      o_valid        <= 1'b0;
      o_instr_abort  <= 1'b0;
      o_instruction  <= '0;
    end else begin
      if (write & i_instr_abort)
        sleep <= 1'b1;

      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr         <= rd_ptr + 1'b1;
        o_instruction  <= mem[rd_ptr].instr;
        o_instr_abort  <= mem[rd_ptr].abort;
        o_valid        <= mem[rd_ptr].valid;
        o_pc_ff        <= mem[rd_ptr].pc;
        o_pc_plus_8_ff <= mem[rd_ptr].pc8;
      end else if (action == ACT_ADVANCE && write) begin
        o_instruction  <= in_entry.instr;
        o_instr_abort  <= in_entry.abort;
        o_valid        <= in_entry.valid;
        o_pc_ff        <= in_entry.pc;
        o_pc_plus_8_ff <= in_entry.pc8;
      end else if (action == ACT_ADVANCE) begin
        o_instruction  <= '0;
        o_instr_abort  <= 1'b0;
        o_valid        <= 1'b0;
      end

      level <= level + LW'(push) - LW'(pop);
    end
  end

endmodule
